pwm_peripheral: RTL and testbench

- Downstream consumer of the SPI register file.
- Takes the five configuration bytes (output enables, PWM enables, duty cycle) and drives 16 output pins.
- Each pin is forced low, forced high, or driven by one shared 8-bit PWM waveform.
- Sits between the SPI register block and the chip's uo_out/uio_out pins.

---
 rtl/pwm_peripheral.sv | 131 +++++++++++++
 tb/tb_pwm_peripheral.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 output pins from the SPI configuration bytes.
// Each pin is forced low, forced high, or follows one shared 8-bit PWM
// waveform whose period is 256 * CLK_DIV system clocks.
// Optional build macro: PWM_SHADOW_EN. When defined, the duty value is
// captured into a shadow register at each period wrap, so a duty change never
// truncates or extends the period in progress.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 10  // system clocks per PWM tick, 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;

  logic        tick_s;
  logic        wrap_s;
  logic        pwm_lvl_s;
  logic [7:0]  duty_act_s;
  logic [15:0] en_out_s;
  logic [15:0] en_pwm_s;

  // 0x00 must give a solid low and 0xFF a solid high (no one-tick dropout)
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
    logic lvl;
    if (duty == 8'hFF) begin
      lvl = 1'b1;
    end else begin
      lvl = (cnt < duty);
    end
    return lvl;
  endfunction

  assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick_s   = (presc_q == PRESC_MAX);
  assign wrap_s   = tick_s && (pwm_cnt_q == 8'hFF);

`ifdef PWM_SHADOW_EN
  logic [7:0] shadow_q, shadow_d;

  // Shadow captures the requested duty only at the 255->0 wrap
  always_comb begin
    shadow_d = shadow_q;
    if (wrap_s) begin
      shadow_d = pwm_duty_cycle;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow register; first period after reset runs at duty 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= 8'h00;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign duty_act_s = shadow_q;
`else
  assign duty_act_s = pwm_duty_cycle;
`endif

  assign pwm_lvl_s = pwm_level(pwm_cnt_q, duty_act_s);

  // Prescaler and PWM counter next state; period_start flags the wrap
  always_comb begin
    presc_d        = presc_q;
    pwm_cnt_d      = pwm_cnt_q;
    period_start_d = 1'b0;
    if (tick_s) begin
      presc_d   = 16'h0000;
      pwm_cnt_d = pwm_cnt_q + 8'h01;
    end else begin
      presc_d   = presc_q + 16'h0001;
      pwm_cnt_d = pwm_cnt_q;
    end
    if (wrap_s) begin
      period_start_d = 1'b1;
    end else begin
      period_start_d = 1'b0;
    end
  end

  // Per-pin mux: disabled -> 0, enabled static -> 1, enabled PWM -> waveform
  always_comb begin
    out_d = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (!en_out_s[i]) begin
        out_d[i] = 1'b0;
      end else if (!en_pwm_s[i]) begin
        out_d[i] = 1'b1;
      end else begin
        out_d[i] = pwm_lvl_s;
      end
    end
  end

  // Timebase and output registers; enable changes never disturb the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q        <= 16'h0000;
      pwm_cnt_q      <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral (CLK_DIV = 10, period 2560 clocks).
// Stimulus pushes expectations; the monitor consumes them on negedges:
// kind 1 = single-sample check, kind 0 = whole-period statistics closed by
// period_start, kind 2 = clocks from reset release to first period_start.
module tb_pwm_peripheral;

  typedef struct {
    int          kind;
    string       name;
    int          len;
    int          hi0;
    int          hi1;
    logic [15:0] and_v;
    logic [15:0] or_v;
    logic [15:0] out_v;
    bit          chk_ps;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  e_lo, e_hi, p_lo, p_hi, duty;
  logic [15:0] out;
  logic        period_start;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // monitor window statistics
  int          w_len = 0, w_hi0 = 0, w_hi1 = 0, cyc = 0;
  logic [15:0] w_and = 16'h0000, w_or = 16'h0000;

  pwm_peripheral #(.CLK_DIV(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (e_lo),
    .en_reg_out_15_8 (e_hi),
    .en_reg_pwm_7_0  (p_lo),
    .en_reg_pwm_15_8 (p_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", nm, act, act, exp_v, exp_v);
    end
  endtask

  // Monitor: consume expectations as the DUT presents samples / periods
  always @(negedge clk) begin
    exp_t e;
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
    if (sb_q.size() > 0 && sb_q[0].kind == 1) begin
      e = sb_q.pop_front();
      chk({e.name, ".out"}, int'(out), int'(e.out_v));
      if (e.chk_ps) chk({e.name, ".period_start"}, int'(period_start), 0);
    end
    if (period_start) begin
      if (sb_q.size() > 0 && sb_q[0].kind == 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".len"}, w_len, e.len);
        chk({e.name, ".hi0"}, w_hi0, e.hi0);
        chk({e.name, ".hi1"}, w_hi1, e.hi1);
        chk({e.name, ".and"}, int'(w_and), int'(e.and_v));
        chk({e.name, ".or"},  int'(w_or),  int'(e.or_v));
      end else if (sb_q.size() > 0 && sb_q[0].kind == 2) begin
        e = sb_q.pop_front();
        chk(e.name, cyc, e.len);
      end
      w_len = 1; w_hi0 = int'(out[0]); w_hi1 = int'(out[1]);
      w_and = out; w_or = out;
    end else begin
      w_len = w_len + 1;
      w_hi0 = w_hi0 + int'(out[0]);
      w_hi1 = w_hi1 + int'(out[1]);
      w_and = w_and & out;
      w_or  = w_or | out;
    end
  end

  task automatic push_sample(input string nm, input logic [15:0] ov, input bit cps);
    exp_t e;
    e = '{kind: 1, name: nm, len: 0, hi0: 0, hi1: 0, and_v: 16'h0, or_v: 16'h0, out_v: ov, chk_ps: cps};
    sb_q.push_back(e);
  endtask

  task automatic push_window(input string nm, input int h0, input int h1,
                             input logic [15:0] av, input logic [15:0] ov);
    exp_t e;
    e = '{kind: 0, name: nm, len: 2560, hi0: h0, hi1: h1, and_v: av, or_v: ov, out_v: 16'h0, chk_ps: 1'b0};
    sb_q.push_back(e);
  endtask

  task automatic push_dist(input string nm, input int d);
    exp_t e;
    e = '{kind: 2, name: nm, len: d, hi0: 0, hi1: 0, and_v: 16'h0, or_v: 16'h0, out_v: 16'h0, chk_ps: 1'b0};
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0) begin
      if (n > 6000) begin
        $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        $fatal(1, "scoreboard did not drain");
      end
      @(negedge clk);
      n++;
    end
    #1;
  endtask

  task automatic wait_ps(input int k);
    int n;
    for (int j = 0; j < k; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n > 3000) begin
          $display("FAIL period_start_timeout: got none in %0d clocks expected 2560", n);
          $fatal(1, "period_start missing");
        end
      end while (!period_start);
    end
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] e_v, input logic [15:0] p_v, input logic [7:0] d_v);
    e_hi = e_v[15:8]; e_lo = e_v[7:0];
    p_hi = p_v[15:8]; p_lo = p_v[7:0];
    duty = d_v;
  endtask

  task automatic run_windows(input string nm, input logic [15:0] e_v, input logic [15:0] p_v,
                             input logic [7:0] d_v, input int nwin, input int h0, input int h1,
                             input logic [15:0] av, input logic [15:0] ov);
    set_cfg(e_v, p_v, d_v);
    wait_ps(2);
    for (int j = 0; j < nwin; j++) push_window(nm, h0, h1, av, ov);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    set_cfg(16'h0000, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    push_sample("reset_state", 16'h0000, 1'b1);
    drain();
    @(negedge clk);
    #1;
    rst = 1'b0;
    push_dist("first_ps_after_reset", 2560);
    drain();

    // static high / disabled pins, one clock after the write
    set_cfg(16'hFFFF, 16'h0000, 8'h00);
    push_sample("en_all_static", 16'hFFFF, 1'b0);
    drain();
    set_cfg(16'h0000, 16'hFFFF, 8'hFF);
    push_sample("en_off_pwm_ff", 16'h0000, 1'b0);
    drain();
    set_cfg(16'h0000, 16'h1234, 8'h80);
    push_sample("en_off_mixed", 16'h0000, 1'b0);
    drain();

    // duty sweep on pin 0
    run_windows("duty80", 16'h0001, 16'h0001, 8'h80, 2, 1280, 0, 16'h0000, 16'h0001);
    run_windows("duty00", 16'h0001, 16'h0001, 8'h00, 2, 0,    0, 16'h0000, 16'h0000);
    run_windows("dutyFF", 16'h0001, 16'h0001, 8'hFF, 2, 2560, 0, 16'h0001, 16'h0001);
    run_windows("duty01", 16'h0001, 16'h0001, 8'h01, 1, 10,   0, 16'h0000, 16'h0001);
    run_windows("pAAAA",  16'hFFFF, 16'hAAAA, 8'h40, 1, 2560, 640, 16'h5555, 16'hFFFF);

    // duty change 0x20 -> 0xC0 while pwm_cnt == 0x50
    set_cfg(16'h0001, 16'h0001, 8'h20);
    wait_ps(2);
    repeat (799) @(negedge clk);
    #1;
    push_sample("pre_change", 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    duty = 8'hC0;
`ifdef PWM_SHADOW_EN
    push_sample("post_change", 16'h0000, 1'b0);
    push_window("change_cur", 320, 0, 16'h0000, 16'h0001);
`else
    push_sample("post_change", 16'h0001, 1'b0);
    push_window("change_cur", 1440, 0, 16'h0000, 16'h0001);
`endif
    push_window("change_next", 1920, 0, 16'h0000, 16'h0001);
    drain();

    // asynchronous reset at pwm_cnt == 0x90 with all pins high
    set_cfg(16'hFFFF, 16'h0000, 8'h00);
    push_sample("pre_reset_high", 16'hFFFF, 1'b0);
    wait_ps(1);
    repeat (1440) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    push_sample("async_reset", 16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    push_dist("ps_after_mid_reset", 2560);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
